wb_arbiter: RTL and testbench

//  Write side of the register file. Merges single-cycle pipeline results (MEM/WB) with results

---
 rtl/wb_arbiter_pkg.sv | 16 +
 rtl/wb_fifo.sv | 52 +++++
 rtl/wb_arbiter.sv | 110 +++++++++++
 tb/tb_wb_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared register-file types and constants for the write-back arbiter slice.
package wb_arbiter_pkg;
  localparam int REG_W   = 32;
  localparam int REG_AW  = 5;
  localparam int REG_NUM = 32;

  typedef logic [REG_W-1:0]  reg_bus_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_bus_t ZERO_WORD = '0;

  typedef struct packed {
    reg_addr_t waddr;
    reg_bus_t  wdata;
  } wb_ent_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of long-latency write-back entries; push is ignored when full, pop when empty.
// Data is visible at dout_o while not empty (show-ahead); no pop->push bypass when full.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  wb_ent_t din_i,
  output logic    full_o,
  input  logic    pop_i,
  output wb_ent_t dout_o,
  output logic    empty_o
);
  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0] ptr_t;

  wb_ent_t mem_q [DEPTH];
  ptr_t    wr_q, wr_d;
  ptr_t    rd_q, rd_d;
  logic    do_push, do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign dout_o  = mem_q[rd_q[PW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + ptr_t'(1);
    if (do_pop)  rd_d = rd_q + ptr_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= din_i;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Merges pipeline and long-latency results onto the single regfile write port, one cycle after grant;
// tracks pending long-latency destinations for RAW stalls and holds the pipe when the FIFO starves.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int LU_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      pipe_we,
  input  reg_addr_t pipe_waddr,
  input  reg_bus_t  pipe_wdata,
  input  logic      lu_valid,
  output logic      lu_ready,
  input  reg_addr_t lu_waddr,
  input  reg_bus_t  lu_wdata,
  input  logic      issue_valid,
  input  reg_addr_t issue_waddr,
  input  logic      re1,
  input  reg_addr_t raddr1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output logic      hazard_stall,
  output logic      pipe_hold,
  output logic      we,
  output reg_addr_t waddr,
  output reg_bus_t  wdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef logic [SW-1:0] starve_t;

  logic               full, empty, pop, pipe_ok;
  wb_ent_t            head;
  starve_t            starve_q, starve_d;
  logic [REG_NUM-1:0] pending_q, pending_d;
  logic               we_q, we_d;
  reg_addr_t          waddr_q, waddr_d;
  reg_bus_t           wdata_q, wdata_d;

  wb_fifo #(.DEPTH(LU_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (lu_valid),
    .din_i   ('{waddr: lu_waddr, wdata: lu_wdata}),
    .full_o  (full),
    .pop_i   (pop),
    .dout_o  (head),
    .empty_o (empty)
  );

  assign lu_ready     = !full;
  assign pipe_ok      = pipe_we && (pipe_waddr != '0);
  assign pipe_hold    = !empty && (starve_q == starve_t'(STARVE_MAX));
  assign pop          = !empty && (pipe_hold || !pipe_ok);
  assign hazard_stall = (re1 && pending_q[raddr1]) || (re2 && pending_q[raddr2]);
  assign we           = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;

  always_comb begin
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    pending_d = pending_q;

    // A popped address-0 entry is consumed silently.
    if (pop) begin
      if (head.waddr != '0) begin
        we_d    = 1'b1;
        waddr_d = head.waddr;
        wdata_d = head.wdata;
      end
      pending_d[head.waddr] = 1'b0;
    end else if (pipe_ok) begin
      we_d    = 1'b1;
      waddr_d = pipe_waddr;
      wdata_d = pipe_wdata;
    end

    if (empty || pop)                         starve_d = '0;
    else if (starve_q != starve_t'(STARVE_MAX)) starve_d = starve_q + starve_t'(1);

    // Issue is applied after the clear so a same-edge set wins.
    if (issue_valid) pending_d[issue_waddr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= ZERO_WORD;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
    end
  end

  a_no_pipe_during_hold: assert property (@(posedge clk) disable iff (rst)
    !(pipe_we && pipe_hold));
  a_no_pipe_to_pending: assert property (@(posedge clk) disable iff (rst)
    !(pipe_ok && pending_q[pipe_waddr]));
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      pipe_we;
  reg_addr_t pipe_waddr;
  reg_bus_t  pipe_wdata;
  logic      lu_valid, lu_ready;
  reg_addr_t lu_waddr;
  reg_bus_t  lu_wdata;
  logic      issue_valid;
  reg_addr_t issue_waddr;
  logic      re1, re2;
  reg_addr_t raddr1, raddr2;
  logic      hazard_stall, pipe_hold, we;
  reg_addr_t waddr;
  reg_bus_t  wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.LU_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_we      (pipe_we),
    .pipe_waddr   (pipe_waddr),
    .pipe_wdata   (pipe_wdata),
    .lu_valid     (lu_valid),
    .lu_ready     (lu_ready),
    .lu_waddr     (lu_waddr),
    .lu_wdata     (lu_wdata),
    .issue_valid  (issue_valid),
    .issue_waddr  (issue_waddr),
    .re1          (re1),
    .raddr1       (raddr1),
    .re2          (re2),
    .raddr2       (raddr2),
    .hazard_stall (hazard_stall),
    .pipe_hold    (pipe_hold),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we = 0; pipe_waddr = '0; pipe_wdata = '0;
    lu_valid = 0; lu_waddr = '0; lu_wdata = '0;
    issue_valid = 0; issue_waddr = '0;
    re1 = 0; raddr1 = '0; re2 = 0; raddr2 = '0;
  endtask

  task automatic pipe(input int a, input int d);
    pipe_we = 1; pipe_waddr = reg_addr_t'(a); pipe_wdata = reg_bus_t'(d);
  endtask

  task automatic lu(input int a, input int d);
    lu_valid = 1; lu_waddr = reg_addr_t'(a); lu_wdata = reg_bus_t'(d);
  endtask

  task automatic chk_wr(input string tag, input int a, input int d);
    chk({tag, ".we"}, 32'(we), 32'd1);
    chk({tag, ".waddr"}, 32'(waddr), 32'(a));
    chk({tag, ".wdata"}, wdata, 32'(d));
  endtask

  initial begin
    // 1: reset
    idle();
    rst = 1;
    tick(); tick();
    chk("rst.we", 32'(we), 0);
    chk("rst.waddr", 32'(waddr), 0);
    chk("rst.wdata", wdata, 0);
    chk("rst.lu_ready", 32'(lu_ready), 1);
    chk("rst.hazard", 32'(hazard_stall), 0);
    chk("rst.hold", 32'(pipe_hold), 0);
    rst = 0;

    // 2: pipe only, then address 0 is dropped
    pipe(5, 'h1234);
    tick();
    chk_wr("pipe5", 5, 'h1234);
    pipe(0, 'h55);
    tick();
    chk("pipe0.we", 32'(we), 0);
    idle();

    // 3: scoreboard set, lu write-back two cycles later clears it
    issue_valid = 1; issue_waddr = 7;
    tick();
    idle();
    re1 = 1; raddr1 = 7;
    #1 chk("sb7.stall", 32'(hazard_stall), 1);
    lu(7, 'hABCD);
    tick();
    lu_valid = 0;
    chk("sb7.we_early", 32'(we), 0);
    chk("sb7.stall_hold", 32'(hazard_stall), 1);
    tick();
    chk_wr("sb7.wb", 7, 'hABCD);
    chk("sb7.stall_clr", 32'(hazard_stall), 0);
    idle();

    // 4: contention, fill FIFO, starve to STARVE_MAX, hold pipe, drain in order
    pipe(10, 'h100); lu(3, 'h11);
    #1 chk("cont.ready0", 32'(lu_ready), 1);
    tick();
    chk_wr("cont.p10", 10, 'h100);
    pipe(11, 'h101); lu(4, 'h22);
    tick();
    lu_valid = 0;
    chk_wr("cont.p11", 11, 'h101);
    chk("cont.full", 32'(lu_ready), 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("cont.nohold", 32'(pipe_hold), 0);
      pipe(12 + i, 'h102 + i);
      tick();
      chk_wr("cont.pN", 12 + i, 'h102 + i);
    end
    chk("cont.hold", 32'(pipe_hold), 1);
    chk("cont.full2", 32'(lu_ready), 0);
    pipe_we = 0;
    tick();
    chk_wr("cont.lu3", 3, 'h11);
    chk("cont.hold_clr", 32'(pipe_hold), 0);
    chk("cont.ready1", 32'(lu_ready), 1);
    tick();
    chk_wr("cont.lu4", 4, 'h22);
    tick();
    chk("cont.drained", 32'(we), 0);
    idle();

    // 5: same-edge clear and set of pending[9]; set wins
    issue_valid = 1; issue_waddr = 9;
    tick();
    idle();
    lu(9, 'h99);
    tick();
    lu_valid = 0;
    issue_valid = 1; issue_waddr = 9;
    tick();
    idle();
    chk_wr("sim.wb9", 9, 'h99);
    re2 = 1; raddr2 = 9;
    #1 chk("sim.stall9", 32'(hazard_stall), 1);
    idle();

    // 6: reset mid-operation drops queue and pending bits
    issue_valid = 1; issue_waddr = 3;
    tick();
    idle();
    pipe(20, 'h1); lu(3, 'h31);
    tick();
    pipe(21, 'h2); lu(6, 'h61);
    tick();
    idle();
    chk("mid.full", 32'(lu_ready), 0);
    re1 = 1; raddr1 = 3;
    #1 chk("mid.stall_pre", 32'(hazard_stall), 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid.ready", 32'(lu_ready), 1);
    chk("mid.we", 32'(we), 0);
    re2 = 1; raddr2 = 9;
    #1 chk("mid.stall", 32'(hazard_stall), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid.no_we", 32'(we), 0);
      chk("mid.no_hold", 32'(pipe_hold), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
